// File: rtl/fw_boot_gate.sv
// rtl/fw_boot_gate.sv - boot-release sequencer around fw_authentication
// Retries failed authentication with backoff and releases the CPU reset only after a pass.
module fw_boot_gate #(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int AUTH_TIMEOUT   = 200000,
  parameter int BACKOFF_CYCLES = 64,
  parameter int RELEASE_DELAY  = 16,
  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             boot_start,
  input  logic             auth_done,
  input  logic             auth_result,
  output logic             auth_trigger,
  output logic             cpu_rst_n_out,
  output logic             boot_ok,
  output logic             boot_locked,
  output logic             boot_fault,
  output logic [ATT_W-1:0] attempt_count,
  output logic [3:0]       boot_status
);

  localparam int MAX_AB  = (AUTH_TIMEOUT > BACKOFF_CYCLES) ? AUTH_TIMEOUT : BACKOFF_CYCLES;
  localparam int CNT_MAX = (MAX_AB > RELEASE_DELAY) ? MAX_AB : RELEASE_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(AUTH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BO_LAST  = CNT_W'(BACKOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_DELAY - 1);
  localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_ATTEMPTS);

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    WAIT_DONE    = 4'd1,
    WAIT_CLEAR   = 4'd2,
    BACKOFF      = 4'd3,
    RELEASE_WAIT = 4'd4,
    BOOTED       = 4'd5,
    LOCKED       = 4'd6,
    FAULT        = 4'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic [ATT_W-1:0] count_d, count_inc;
  logic             pass_q, pass_d;
  logic             trigger_d, cpu_rst_n_d, ok_d, locked_d, fault_d;

  assign timer_inc = (timer_q == {CNT_W{1'b1}}) ? timer_q : timer_q + CNT_W'(1);
  assign count_inc = (attempt_count == ATT_MAX) ? attempt_count : attempt_count + ATT_W'(1);

  // Outputs are registered from the next-state decode so they switch on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      pass_q        <= 1'b0;
      attempt_count <= '0;
      auth_trigger  <= 1'b0;
      cpu_rst_n_out <= 1'b0;
      boot_ok       <= 1'b0;
      boot_locked   <= 1'b0;
      boot_fault    <= 1'b0;
      boot_status   <= 4'd0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pass_q        <= pass_d;
      attempt_count <= count_d;
      auth_trigger  <= trigger_d;
      cpu_rst_n_out <= cpu_rst_n_d;
      boot_ok       <= ok_d;
      boot_locked   <= locked_d;
      boot_fault    <= fault_d;
      boot_status   <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pass_d  = pass_q;
    count_d = attempt_count;
    unique case (state_q)
      IDLE: begin
        if (boot_start) begin
          state_d = WAIT_DONE;
          timer_d = '0;
        end
      end
      WAIT_DONE: begin
        if (auth_done) begin
          pass_d  = auth_result;
          timer_d = '0;
          state_d = WAIT_CLEAR;
        end else if (timer_q == TO_LAST) begin
          state_d = FAULT;
        end else begin
          timer_d = timer_inc;
        end
      end
      WAIT_CLEAR: begin
        if (!auth_done) begin
          timer_d = '0;
          if (pass_q) begin
            state_d = RELEASE_WAIT;
          end else begin
            count_d = count_inc;
            state_d = (count_inc == ATT_MAX) ? LOCKED : BACKOFF;
          end
        end else if (timer_q == TO_LAST) begin
          state_d = FAULT;
        end else begin
          timer_d = timer_inc;
        end
      end
      BACKOFF: begin
        // Hold at the end of backoff if done is somehow high so the upstream never sees a dirty restart.
        if (timer_q == BO_LAST) begin
          if (!auth_done) begin
            state_d = WAIT_DONE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_inc;
        end
      end
      RELEASE_WAIT: begin
        if (timer_q == REL_LAST) begin
          state_d = BOOTED;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_comb begin
    trigger_d   = (state_d == WAIT_DONE);
    cpu_rst_n_d = (state_d == BOOTED);
    ok_d        = (state_d == BOOTED);
    locked_d    = (state_d == LOCKED);
    fault_d     = (state_d == FAULT);
  end

endmodule

// File: tb/tb_fw_boot_gate.sv
// tb/tb_fw_boot_gate.sv - directed self-checking bench for fw_boot_gate
module tb_fw_boot_gate;

  localparam int MA = 3;
  localparam int TO = 100;
  localparam int BO = 64;
  localparam int RD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       boot_start = 1'b0, auth_done = 1'b0, auth_result = 1'b0;
  logic       auth_trigger, cpu_rst_n_out, boot_ok, boot_locked, boot_fault;
  logic [1:0] attempt_count;
  logic [3:0] boot_status;

  logic       boot_start2 = 1'b0, auth_done2 = 1'b0, auth_result2 = 1'b0;
  logic       auth_trigger2, cpu_rst_n_out2, boot_ok2, boot_locked2, boot_fault2;
  logic [0:0] attempt_count2;
  logic [3:0] boot_status2;

  int n_checks = 0;
  int n_fail = 0;
  int n_trig;

  always #5 clk = ~clk;

  fw_boot_gate #(.MAX_ATTEMPTS(MA), .AUTH_TIMEOUT(TO), .BACKOFF_CYCLES(BO), .RELEASE_DELAY(RD)) dut (
    .clk(clk), .rst_n(rst_n), .boot_start(boot_start), .auth_done(auth_done),
    .auth_result(auth_result), .auth_trigger(auth_trigger), .cpu_rst_n_out(cpu_rst_n_out),
    .boot_ok(boot_ok), .boot_locked(boot_locked), .boot_fault(boot_fault),
    .attempt_count(attempt_count), .boot_status(boot_status)
  );

  fw_boot_gate #(.MAX_ATTEMPTS(1), .AUTH_TIMEOUT(TO), .BACKOFF_CYCLES(BO), .RELEASE_DELAY(RD)) dut1 (
    .clk(clk), .rst_n(rst_n), .boot_start(boot_start2), .auth_done(auth_done2),
    .auth_result(auth_result2), .auth_trigger(auth_trigger2), .cpu_rst_n_out(cpu_rst_n_out2),
    .boot_ok(boot_ok2), .boot_locked(boot_locked2), .boot_fault(boot_fault2),
    .attempt_count(attempt_count2), .boot_status(boot_status2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_status"}, 32'(boot_status), 32'd0);
    chk({tag, "_trig"}, 32'(auth_trigger), 32'd0);
    chk({tag, "_cpu"}, 32'(cpu_rst_n_out), 32'd0);
    chk({tag, "_ok"}, 32'(boot_ok), 32'd0);
    chk({tag, "_locked"}, 32'(boot_locked), 32'd0);
    chk({tag, "_fault"}, 32'(boot_fault), 32'd0);
    chk({tag, "_count"}, 32'(attempt_count), 32'd0);
  endtask

  // Asserted mid-cycle: outputs must clear before any clock edge.
  task automatic reset_async(input string tag);
    rst_n = 1'b0;
    boot_start = 1'b0;
    auth_done = 1'b0;
    auth_result = 1'b0;
    #1;
    check_cleared(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    chk("start_trig", 32'(auth_trigger), 32'd1);
    chk("start_status", 32'(boot_status), 32'd1);
  endtask

  task automatic do_attempt(input logic r);
    repeat (3) tick();
    auth_done = 1'b1;
    auth_result = r;
    tick();
    chk("att_trig_drop", 32'(auth_trigger), 32'd0);
    chk("att_wait_clear", 32'(boot_status), 32'd2);
    tick();
    auth_done = 1'b0;
    auth_result = 1'b0;
    tick();
  endtask

  task automatic finish_release(input string tag);
    chk({tag, "_relwait"}, 32'(boot_status), 32'd4);
    repeat (RD - 1) tick();
    chk({tag, "_still_held"}, 32'(cpu_rst_n_out), 32'd0);
    chk({tag, "_still_relwait"}, 32'(boot_status), 32'd4);
    tick();
    chk({tag, "_booted"}, 32'(boot_status), 32'd5);
    chk({tag, "_cpu_rel"}, 32'(cpu_rst_n_out), 32'd1);
    chk({tag, "_ok"}, 32'(boot_ok), 32'd1);
  endtask

  initial begin
    repeat (2) tick();
    check_cleared("reset");
    rst_n = 1'b1;
    auth_done = 1'b1;
    tick();
    auth_done = 1'b0;
    chk("idle_ignores_done", 32'(boot_status), 32'd0);

    // Pass on the first try
    do_start();
    repeat (50) tick();
    chk("s1_trig_hold", 32'(auth_trigger), 32'd1);
    auth_done = 1'b1;
    auth_result = 1'b1;
    tick();
    chk("s1_trig_low", 32'(auth_trigger), 32'd0);
    chk("s1_wait_clear", 32'(boot_status), 32'd2);
    tick();
    auth_done = 1'b0;
    auth_result = 1'b0;
    tick();
    finish_release("s1");
    chk("s1_count", 32'(attempt_count), 32'd0);
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    repeat (5) tick();
    chk("s1_booted_sticky", 32'(boot_status), 32'd5);
    chk("s1_booted_trig", 32'(auth_trigger), 32'd0);

    // Fail then pass
    reset_async("s2_rst");
    do_start();
    do_attempt(1'b0);
    chk("s2_backoff", 32'(boot_status), 32'd3);
    chk("s2_count1", 32'(attempt_count), 32'd1);
    repeat (BO - 1) tick();
    chk("s2_backoff_end", 32'(boot_status), 32'd3);
    chk("s2_backoff_trig", 32'(auth_trigger), 32'd0);
    tick();
    chk("s2_retrigger", 32'(auth_trigger), 32'd1);
    chk("s2_wait_done", 32'(boot_status), 32'd1);
    do_attempt(1'b1);
    finish_release("s2");
    chk("s2_count_final", 32'(attempt_count), 32'd1);

    // Lockout after three failures
    reset_async("s3_rst");
    do_start();
    do_attempt(1'b0);
    repeat (BO) tick();
    do_attempt(1'b0);
    chk("s3_count2", 32'(attempt_count), 32'd2);
    chk("s3_backoff2", 32'(boot_status), 32'd3);
    repeat (BO) tick();
    do_attempt(1'b0);
    chk("s3_locked_status", 32'(boot_status), 32'd6);
    chk("s3_locked", 32'(boot_locked), 32'd1);
    chk("s3_count3", 32'(attempt_count), 32'd3);
    chk("s3_cpu_held", 32'(cpu_rst_n_out), 32'd0);
    n_trig = 0;
    boot_start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      boot_start = 1'b0;
      if (auth_trigger) n_trig++;
    end
    chk("s3_no_4th_trigger", 32'(n_trig), 32'd0);
    chk("s3_still_locked", 32'(boot_status), 32'd6);

    // Done never rises
    reset_async("s4_rst");
    do_start();
    repeat (TO - 1) tick();
    chk("s4_before_to", 32'(boot_status), 32'd1);
    tick();
    chk("s4_fault_status", 32'(boot_status), 32'd7);
    chk("s4_fault_trig", 32'(auth_trigger), 32'd0);
    chk("s4_fault", 32'(boot_fault), 32'd1);

    // Done on the timeout cycle beats the timeout
    reset_async("s4b_rst");
    do_start();
    repeat (TO - 1) tick();
    auth_done = 1'b1;
    auth_result = 1'b1;
    tick();
    chk("s4b_done_wins", 32'(boot_status), 32'd2);
    tick();
    auth_done = 1'b0;
    auth_result = 1'b0;
    tick();
    chk("s4b_relwait", 32'(boot_status), 32'd4);
    repeat (3) tick();

    // Reset in RELEASE_WAIT, then done stuck high
    reset_async("mid_relwait");
    do_start();
    repeat (3) tick();
    auth_done = 1'b1;
    auth_result = 1'b1;
    tick();
    chk("s5_wait_clear", 32'(boot_status), 32'd2);
    repeat (TO - 1) tick();
    chk("s5_before_to", 32'(boot_status), 32'd2);
    tick();
    chk("s5_fault_status", 32'(boot_status), 32'd7);
    chk("s5_fault", 32'(boot_fault), 32'd1);
    chk("s5_cpu_held", 32'(cpu_rst_n_out), 32'd0);
    auth_done = 1'b0;
    auth_result = 1'b0;

    // Reset in BACKOFF, then a fresh full pass
    reset_async("s6_rst");
    do_start();
    do_attempt(1'b0);
    repeat (10) tick();
    chk("s6_in_backoff", 32'(boot_status), 32'd3);
    reset_async("mid_backoff");
    do_start();
    do_attempt(1'b1);
    finish_release("s6");
    chk("s6_count", 32'(attempt_count), 32'd0);

    // MAX_ATTEMPTS=1 with boot_start held high throughout
    boot_start2 = 1'b1;
    tick();
    chk("m1_trig", 32'(auth_trigger2), 32'd1);
    repeat (3) tick();
    auth_done2 = 1'b1;
    auth_result2 = 1'b0;
    tick();
    chk("m1_trig_drop", 32'(auth_trigger2), 32'd0);
    tick();
    auth_done2 = 1'b0;
    tick();
    chk("m1_locked_status", 32'(boot_status2), 32'd6);
    chk("m1_locked", 32'(boot_locked2), 32'd1);
    chk("m1_count", 32'(attempt_count2), 32'd1);
    n_trig = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (auth_trigger2) n_trig++;
    end
    chk("m1_single_attempt", 32'(n_trig), 32'd0);
    boot_start2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
